// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one register-file write port between the pipeline
// write-back stage and a 2-entry aux queue; optional WB_ARB_STARVE_EN.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_wr_en,
    input  logic [2:0]  pipe_wr_reg,
    input  logic [15:0] pipe_wr_data,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [2:0]  aux_wr_reg,
    input  logic [15:0] aux_wr_data,
    output logic        rf_wr_en,
    output logic [2:0]  rf_wr_reg,
    output logic [15:0] rf_wr_data,
    output logic        pipe_stall,
    output logic        aux_squash
);

    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] data;
    } aux_ent_t;

    aux_ent_t   q_mem [2];
    aux_ent_t   head;
    aux_ent_t   in_ent;
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] q_cnt;
    logic [1:0] q_cnt_nxt;
    logic       q_empty;
    logic       q_full;
    logic       push;
    logic       pop;
    logic       pipe_gnt;
    logic       aux_gnt;
    logic       squash;

    assign q_empty   = (q_cnt == 2'd0);
    assign q_full    = (q_cnt == 2'd2);
    assign head      = q_mem[rd_ptr];
    assign in_ent    = '{rd: aux_wr_reg, data: aux_wr_data};
    assign aux_ready = rst_n && !q_full;
    assign push      = aux_valid && aux_ready;
    assign pop       = aux_gnt || squash;
    assign aux_squash = squash;

    // Grant: pipeline first unless stalled; a freshly pushed entry waits a cycle
    always_comb begin
        pipe_gnt = 1'b0;
        aux_gnt  = 1'b0;
        squash   = 1'b0;
        if (rst_n) begin
            pipe_gnt = pipe_wr_en && !pipe_stall;
            aux_gnt  = !pipe_gnt && !q_empty;
            squash   = pipe_gnt && !q_empty &&
                       (pipe_wr_reg == head.rd);
        end
    end

    // Write-port mux; address and data read as zero when idle
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_reg  = 3'd0;
        rf_wr_data = 16'd0;
        unique case (1'b1)
            pipe_gnt: begin
                rf_wr_en   = 1'b1;
                rf_wr_reg  = pipe_wr_reg;
                rf_wr_data = pipe_wr_data;
            end
            aux_gnt: begin
                rf_wr_en   = 1'b1;
                rf_wr_reg  = head.rd;
                rf_wr_data = head.data;
            end
            default: ;
        endcase
    end

    // Occupancy after this edge
    always_comb begin
        q_cnt_nxt = q_cnt;
        unique case ({push, pop})
            2'b10:   q_cnt_nxt = q_cnt + 2'd1;
            2'b01:   q_cnt_nxt = q_cnt - 2'd1;
            default: q_cnt_nxt = q_cnt;
        endcase
    end

    // Aux FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_cnt    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            q_mem[0] <= '0;
            q_mem[1] <= '0;
        end else begin
            q_cnt <= q_cnt_nxt;
            if (push) begin
                q_mem[wr_ptr] <= in_ent;
                wr_ptr        <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
        end
    end

`ifdef WB_ARB_STARVE_EN
    logic [3:0] starve_cnt;
    logic [3:0] starve_inc;
    logic       starve_hit;
    logic       stall_q;

    assign starve_inc = starve_cnt + 4'd1;
    assign starve_hit = !q_empty && pipe_gnt && !squash &&
                        (starve_inc == 4'(STARVE_LIMIT));
    assign pipe_stall = stall_q;

    // Count pipeline wins over a waiting head; force a one-cycle stall at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
            stall_q    <= 1'b0;
        end else begin
            stall_q <= starve_hit && (q_cnt_nxt != 2'd0);
            if (q_empty || aux_gnt || squash || starve_hit) begin
                starve_cnt <= 4'd0;
            end else if (pipe_gnt) begin
                starve_cnt <= starve_inc;
            end
        end
    end
`else
    logic [3:0] unused_limit;

    assign unused_limit = 4'(STARVE_LIMIT);
    assign pipe_stall   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed stimulus, queue-based reference model checked
// every cycle, plus literal expectations from the worked examples.
module tb_wb_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        pipe_wr_en;
    logic [2:0]  pipe_wr_reg;
    logic [15:0] pipe_wr_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [2:0]  aux_wr_reg;
    logic [15:0] aux_wr_data;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_reg;
    logic [15:0] rf_wr_data;
    logic        pipe_stall;
    logic        aux_squash;

    int passed = 0;
    int total  = 0;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_wr_en   (pipe_wr_en),
        .pipe_wr_reg  (pipe_wr_reg),
        .pipe_wr_data (pipe_wr_data),
        .aux_valid    (aux_valid),
        .aux_ready    (aux_ready),
        .aux_wr_reg   (aux_wr_reg),
        .aux_wr_data  (aux_wr_data),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_reg    (rf_wr_reg),
        .rf_wr_data   (rf_wr_data),
        .pipe_stall   (pipe_stall),
        .aux_squash   (aux_squash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: pending aux writes in program order
    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] d;
    } ent_t;

    ent_t q[$];
`ifdef WB_ARB_STARVE_EN
    int waits   = 0;
    bit stall_m = 1'b0;
`endif

    always @(negedge clk) begin : model
        logic        pg, ag, sq, rdy, stl, busy;
        logic        ee;
        logic [2:0]  er;
        logic [15:0] ed;
        if (!rst_n) begin
            chk("rst_rf_wr_en", rf_wr_en, 0);
            chk("rst_aux_ready", aux_ready, 0);
            chk("rst_aux_squash", aux_squash, 0);
            chk("rst_pipe_stall", pipe_stall, 0);
            q.delete();
`ifdef WB_ARB_STARVE_EN
            waits   = 0;
            stall_m = 1'b0;
`endif
        end else begin
            stl = 1'b0;
`ifdef WB_ARB_STARVE_EN
            stl = stall_m;
`endif
            busy = q.size() > 0;
            rdy  = q.size() < 2;
            pg   = pipe_wr_en && !stl;
            ag   = !pg && busy;
            sq   = pg && busy && (pipe_wr_reg == q[0].r);
            ee = 1'b0; er = 3'd0; ed = 16'd0;
            if (pg) begin
                ee = 1'b1; er = pipe_wr_reg; ed = pipe_wr_data;
            end else if (ag) begin
                ee = 1'b1; er = q[0].r; ed = q[0].d;
            end
            chk("model_rf_wr_en", rf_wr_en, ee);
            chk("model_rf_wr_reg", rf_wr_reg, er);
            chk("model_rf_wr_data", rf_wr_data, ed);
            chk("model_aux_ready", aux_ready, rdy);
            chk("model_aux_squash", aux_squash, sq);
            chk("model_pipe_stall", pipe_stall, stl);
            if (ag || sq) void'(q.pop_front());
            if (aux_valid && rdy) q.push_back('{r: aux_wr_reg, d: aux_wr_data});
`ifdef WB_ARB_STARVE_EN
            stall_m = 1'b0;
            if (pg && !sq && busy) begin
                waits++;
                if (waits == LIMIT) begin
                    stall_m = q.size() > 0;
                    waits   = 0;
                end
            end else begin
                waits = 0;
            end
`endif
        end
    end

    task automatic tick(input logic pe, input logic [2:0] pr,
                        input logic [15:0] pd, input logic av,
                        input logic [2:0] ar, input logic [15:0] ad);
        @(posedge clk);
        #1;
        pipe_wr_en   = pe;
        pipe_wr_reg  = pr;
        pipe_wr_data = pd;
        aux_valid    = av;
        aux_wr_reg   = ar;
        aux_wr_data  = ad;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        pipe_wr_en = 1'b0; pipe_wr_reg = 3'd0; pipe_wr_data = 16'd0;
        aux_valid = 1'b0; aux_wr_reg = 3'd0; aux_wr_data = 16'd0;
        @(negedge clk);
        chk("lit_reset_ready", aux_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("lit_post_reset_ready", aux_ready, 1);

        // Pipeline write on idle queue
        tick(1, 3'd3, 16'h1234, 0, 3'd0, 16'h0);
        chk("lit_pipe_en", rf_wr_en, 1);
        chk("lit_pipe_reg", rf_wr_reg, 3);
        chk("lit_pipe_data", rf_wr_data, 16'h1234);

        // Aux write lands the next cycle
        tick(0, 3'd0, 16'h0, 1, 3'd5, 16'hBEEF);
        chk("lit_push_no_write", rf_wr_en, 0);
        chk("lit_push_ready", aux_ready, 1);
        tick(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        chk("lit_aux_reg", rf_wr_reg, 5);
        chk("lit_aux_data", rf_wr_data, 16'hBEEF);
        chk("lit_aux_ready_stays", aux_ready, 1);

        // Fill queue while the pipeline is busy, third offer refused
        tick(1, 3'd0, 16'h0001, 1, 3'd1, 16'h1111);
        tick(1, 3'd0, 16'h0002, 1, 3'd2, 16'h2222);
        tick(1, 3'd0, 16'h0003, 1, 3'd7, 16'h7777);
        chk("lit_full_ready", aux_ready, 0);
        tick(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        chk("lit_drain1_data", rf_wr_data, 16'h1111);
        tick(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        chk("lit_drain2_data", rf_wr_data, 16'h2222);
        tick(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        chk("lit_drain_empty", rf_wr_en, 0);

        // Younger pipeline write to the head register squashes it
        tick(1, 3'd0, 16'h0009, 1, 3'd2, 16'h5555);
        tick(1, 3'd2, 16'h00AA, 0, 3'd0, 16'h0);
        chk("lit_squash", aux_squash, 1);
        chk("lit_squash_data", rf_wr_data, 16'h00AA);
        tick(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        chk("lit_squash_pulse", aux_squash, 0);
        chk("lit_squash_popped", rf_wr_en, 0);

        // Continuous pipeline traffic against one aux entry
        tick(1, 3'd1, 16'h0101, 1, 3'd6, 16'h6666);
        tick(1, 3'd4, 16'h0404, 0, 3'd0, 16'h0);
        tick(1, 3'd1, 16'h0105, 0, 3'd0, 16'h0);
        tick(1, 3'd4, 16'h0406, 0, 3'd0, 16'h0);
        tick(1, 3'd1, 16'h0107, 0, 3'd0, 16'h0);
        tick(1, 3'd4, 16'h0408, 0, 3'd0, 16'h0);
`ifdef WB_ARB_STARVE_EN
        chk("lit_stall", pipe_stall, 1);
        chk("lit_stall_reg", rf_wr_reg, 6);
        chk("lit_stall_data", rf_wr_data, 16'h6666);
        tick(1, 3'd4, 16'h0408, 0, 3'd0, 16'h0);
        chk("lit_stall_pulse", pipe_stall, 0);
        chk("lit_after_stall_data", rf_wr_data, 16'h0408);
        tick(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
`else
        chk("lit_no_stall", pipe_stall, 0);
        chk("lit_no_stall_data", rf_wr_data, 16'h0408);
        tick(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        chk("lit_late_aux_data", rf_wr_data, 16'h6666);
`endif

        // Reset with two entries queued
        tick(1, 3'd0, 16'h0010, 1, 3'd3, 16'h3333);
        tick(1, 3'd0, 16'h0011, 1, 3'd5, 16'h5555);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        aux_valid = 1'b0;
        @(negedge clk);
        chk("lit_rst_rf", rf_wr_en, 0);
        chk("lit_rst_ready", aux_ready, 0);
        chk("lit_rst_stall", pipe_stall, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        chk("lit_rst_discard", rf_wr_en, 0);
        chk("lit_rst_empty", aux_ready, 1);
        tick(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive cycles an aux entry may wait before a pipeline stall is forced (legal 1..15).
REQ-002 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock, rising-edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 pipe_wr_en  in  1  pipeline write-back stage requests a register write.
REQ-006 pipe_wr_reg  in  3  pipeline destination register.
REQ-007 pipe_wr_data  in  16  pipeline write data (write-back mux result).
REQ-008 aux_valid  in  1  auxiliary (multi-cycle unit) write offered.
REQ-009 aux_ready  out  1  aux queue can accept; transfer on aux_valid && aux_ready.
REQ-010 aux_wr_reg  in  3  aux destination register.
REQ-011 aux_wr_data  in  16  aux write data.
REQ-012 rf_wr_en  out  1  register-file write enable.
REQ-013 rf_wr_reg  out  3  register-file write address.
REQ-014 rf_wr_data  out  16  register-file write data.
REQ-015 pipe_stall  out  1  registered; holds the pipeline write-back stage for one cycle.
REQ-016 aux_squash  out  1  pulse; aux queue head discarded as stale.

Function
REQ-017 Aux queue: 2-entry FIFO, in-order; aux_ready = not full, combinational from the registered count only.
REQ-018 Grant, combinational each cycle: pipe_wr_en && !pipe_stall -> pipeline; else queue non-empty -> aux head; else no write.
REQ-019 rf_wr_* are combinational from the granted source; rf_wr_en low when nothing is granted; rf_wr_reg and rf_wr_data are 0 when rf_wr_en is low.
REQ-020 An aux head is popped on the clock edge of its grant; push and pop in the same cycle leave the count unchanged.
REQ-021 Push while full is ignored and never corrupts the queue.
REQ-022 Push into an empty queue is not grantable in the same cycle; it is eligible from the next cycle.
REQ-023 Pipeline writes are program-order younger. Squash condition: pipeline granted, queue non-empty, and pipe_wr_reg == head register.
REQ-024 On the squash condition, aux_squash = 1 and the head is popped without being written.
REQ-025 Starvation counter, 4 bits: increments each cycle the queue is non-empty and the pipeline is granted without a squash.
REQ-026 The starvation counter clears on any aux grant, on any squash, and whenever the queue is empty.
REQ-027 When the counter equals STARVE_LIMIT, pipe_stall is 1 the next cycle for exactly one cycle, and the counter clears.
REQ-028 During pipe_stall the aux head is granted; the pipeline keeps pipe_wr_* stable and is granted the following cycle.
REQ-029 pipe_stall is never asserted with an empty queue; it deasserts if the queue has drained.

Reset
REQ-030 rst_n low asynchronously empties the queue, clears the counter, and forces pipe_stall = 0.
REQ-031 Under reset: aux_ready = 0, rf_wr_en = 0, aux_squash = 0.
REQ-032 First grant and first push are allowed on the first rising edge after rst_n deasserts.
REQ-033 Reset mid-operation discards queued entries without writing them.

Configuration
REQ-034 Macro WB_ARB_STARVE_EN, when defined, includes the starvation counter and pipe_stall behaviour of REQ-025..REQ-029.
REQ-035 When WB_ARB_STARVE_EN is undefined: no counter is built, pipe_stall is tied 0, and aux entries are granted only in cycles with pipe_wr_en = 0; squash behaviour is unchanged.

Verification
REQ-036 Idle queue, pipe_wr_en=1 reg 3 data 0x1234 -> same cycle rf_wr_en=1, rf_wr_reg=3, rf_wr_data=0x1234.
REQ-037 pipe_wr_en=0; push aux reg 5 data 0xBEEF -> written the next cycle; aux_ready stays 1.
REQ-038 Two aux pushes, third offered -> aux_ready=0 and third not accepted; entries drain in order on idle pipeline cycles.
REQ-039 Queue head reg 2, pipeline writes reg 2 data 0x00AA -> rf gets 0x00AA, aux_squash=1 for one cycle, head popped.
REQ-040 WB_ARB_STARVE_EN, STARVE_LIMIT=4, pipe_wr_en held 1 to regs 1/4, one aux entry reg 6 -> pipe_stall pulses after 4 pipeline grants, reg 6 written that cycle, pipeline write granted next.
REQ-041 rst_n low with 2 queued entries -> no rf write, aux_ready=0, pipe_stall=0; after release the queue is empty.
